uart_core: RTL and testbench
============================

UART_CORE -- requirements
Module: uart_core

Interface
REQ-001 Parameter CLKS_PER_BIT, default 868, clk cycles per serial bit (100 MHz / 115200); legal minimum 4.
REQ-002 Parameter DATA_BITS, default 8, payload bits per frame; legal range 5..9.
REQ-003 Parameter PARITY_EN, default 0, 1 inserts and checks a parity bit.
REQ-004 Parameter PARITY_ODD, default 0, 1 selects odd parity, 0 selects even; ignored when PARITY_EN=0.
REQ-005 Parameter STOP_BITS, default 1, stop bits transmitted (1 or 2); the receiver checks only the first.
REQ-006 clk  input  1  single system clock; all logic on the rising edge.
REQ-007 rst  input  1  synchronous, active-high reset.
REQ-008 tx_data  input  DATA_BITS  byte to transmit.
REQ-009 tx_valid  input  1  tx_data is valid.
REQ-010 tx_ready  output  1  transmitter can accept a word.
REQ-011 tx  output  1  serial output, idles high.
REQ-012 rx  input  1  serial input, asynchronous to clk.
REQ-013 rx_data  output  DATA_BITS  last received word.
REQ-014 rx_valid  output  1  rx_data holds an unread word.
REQ-015 rx_ready  input  1  consumer takes rx_data.
REQ-016 rx_parity_err, rx_frame_err  output  1 each  status of the word in rx_data.
REQ-017 rx_overrun  output  1  sticky; a frame was lost because rx_valid was still high.
REQ-018 loopback  input  1  routes the internal TX stream to the RX path.

Function
REQ-019 A TX word SHALL be accepted on a cycle with tx_valid && tx_ready, and tx_ready SHALL be high only in TX state IDLE.
REQ-020 The TX FSM SHALL step IDLE -> START -> DATA -> PARITY (only if PARITY_EN) -> STOP -> IDLE, holding each bit for exactly CLKS_PER_BIT cycles.
REQ-021 tx SHALL go low on the cycle after acceptance and send data LSB first, then parity, then STOP_BITS high bits.
REQ-022 tx_ready SHALL rise on the cycle after the last stop bit ends, so back-to-back words have no idle gap.
REQ-023 rx SHALL pass through a 2-flop synchroniser before any use; this adds 2 cycles of latency.
REQ-024 The RX FSM SHALL step IDLE -> START -> DATA -> PARITY (if enabled) -> STOP -> IDLE, leaving IDLE on a synchronised high-to-low edge.
REQ-025 The receiver SHALL resample the line at CLKS_PER_BIT/2 (integer division); if the line is high, RX returns to IDLE with no output (glitch rejection).
REQ-026 Each subsequent bit SHALL be sampled once, CLKS_PER_BIT cycles after the previous sample.
REQ-027 At the stop sample, rx_data, rx_parity_err and rx_frame_err (stop sampled low) SHALL update and rx_valid SHALL be set on the next cycle.
REQ-028 rx_valid SHALL clear on the cycle after rx_valid && rx_ready.
REQ-029 If a frame completes while rx_valid is high and rx_ready is low, rx_data and its flags SHALL be kept, the new frame discarded, and rx_overrun set.
REQ-030 If a frame completes on the same cycle as rx_valid && rx_ready, the new frame SHALL load, rx_valid SHALL stay high, and no overrun SHALL be flagged.
REQ-031 rx_overrun SHALL clear only on rst.
REQ-032 With loopback=1, the RX FSM SHALL take the internal TX bit and bypass the synchroniser, and the tx pin SHALL be held high.
REQ-033 Changing loopback SHALL take effect only while both FSMs are in IDLE; mid-frame changes are deferred.
REQ-034 After the frame-error stop sample, RX SHALL wait for the line to return high before re-arming (break condition yields one word).

Reset
REQ-035 On rst, tx=1, tx_ready=0 for that cycle then 1, rx_valid=0, rx_data=0, and all error flags=0.
REQ-036 On rst, both FSMs and all bit and baud counters SHALL return to IDLE/0 in the same cycle, abandoning any frame in progress (the tx line returns high immediately).
REQ-037 rst asserted mid-frame SHALL NOT produce an rx_valid for the partial frame.

Verification (CLKS_PER_BIT=4 unless noted)
REQ-038 Send tx_data=8'hA5, PARITY_EN=0 -> tx shows 0,1,0,1,0,0,1,0,1,1, each 4 cycles long; tx_ready low for 40 cycles.
REQ-039 Loopback=1 with 8'hFF then 8'h00 sent back-to-back and rx_ready=1 -> rx_data 8'hFF then 8'h00, both error flags 0, tx pin constantly 1.
REQ-040 PARITY_EN=1, PARITY_ODD=0, rx frame 8'h03 with parity bit 1 -> rx_parity_err=1, rx_data=8'h03.
REQ-041 A 1-cycle low glitch on rx -> no rx_valid, and RX returns to IDLE after 2 cycles.
REQ-042 Two frames received with rx_ready=0 -> rx_data keeps the first word and rx_overrun=1; rx_ready then clears rx_valid only.
REQ-043 rst asserted at TX data bit 3 -> tx=1 next cycle, tx_ready=1 one cycle later, and no rx_valid in loopback.

Source files
------------

// File: rtl/uart_core.sv
// Full-duplex UART: framed transmitter, synchronised oversampling receiver,
// single-word receive buffer with overrun tracking, and internal loopback.
module uart_core #(
  parameter int CLKS_PER_BIT = 868,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 rx_parity_err,
  output logic                 rx_frame_err,
  output logic                 rx_overrun,
  input  logic                 loopback
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] MID_CNT  = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_BITS - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  function automatic logic parity_of(input logic [DATA_BITS-1:0] d);
    return (^d) ^ (PARITY_ODD != 0);
  endfunction

  state_t               tx_state, rx_state;
  logic [CNT_W-1:0]     tx_cnt, rx_cnt;
  logic [BIT_W-1:0]     tx_idx, rx_idx;
  logic                 tx_stop_idx;
  logic [DATA_BITS-1:0] tx_shift, rx_shift;
  logic                 tx_par, rx_par;
  logic                 tx_bit;
  logic                 lb_act;
  logic                 rx_meta_p0, rx_sync_p1;
  logic                 rx_line, rx_prev;
  logic                 vld_p1;
  logic                 frame_done;

  // Loopback mode only switches between frames so neither side sees a torn frame.
  always_ff @(posedge clk) begin
    if (rst) lb_act <= 1'b0;
    else if (tx_state == S_IDLE && rx_state == S_IDLE) lb_act <= loopback;
  end

  assign tx = lb_act ? 1'b1 : tx_bit;

  // TX: tx_bit is registered so the pin changes exactly at bit boundaries
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state    <= S_IDLE;
      tx_cnt      <= '0;
      tx_idx      <= '0;
      tx_stop_idx <= 1'b0;
      tx_bit      <= 1'b1;
      tx_ready    <= 1'b0;
    end else begin
      case (tx_state)
        S_IDLE: begin
          tx_ready <= 1'b1;
          if (tx_valid && tx_ready) begin
            tx_ready <= 1'b0;
            tx_shift <= tx_data;
            tx_par   <= parity_of(tx_data);
            tx_bit   <= 1'b0;
            tx_cnt   <= '0;
            tx_state <= S_START;
          end
        end
        S_START: begin
          if (tx_cnt == LAST_CNT) begin
            tx_cnt   <= '0;
            tx_idx   <= '0;
            tx_bit   <= tx_shift[0];
            tx_state <= S_DATA;
          end else tx_cnt <= tx_cnt + CNT_W'(1);
        end
        S_DATA: begin
          if (tx_cnt == LAST_CNT) begin
            tx_cnt <= '0;
            if (tx_idx == LAST_BIT) begin
              tx_stop_idx <= 1'b0;
              if (PARITY_EN != 0) begin
                tx_bit   <= tx_par;
                tx_state <= S_PARITY;
              end else begin
                tx_bit   <= 1'b1;
                tx_state <= S_STOP;
              end
            end else begin
              tx_idx   <= tx_idx + BIT_W'(1);
              tx_bit   <= tx_shift[1];
              tx_shift <= tx_shift >> 1;
            end
          end else tx_cnt <= tx_cnt + CNT_W'(1);
        end
        S_PARITY: begin
          if (tx_cnt == LAST_CNT) begin
            tx_cnt   <= '0;
            tx_bit   <= 1'b1;
            tx_state <= S_STOP;
          end else tx_cnt <= tx_cnt + CNT_W'(1);
        end
        S_STOP: begin
          if (tx_cnt == LAST_CNT) begin
            tx_cnt <= '0;
            if (STOP_BITS == 2 && !tx_stop_idx) tx_stop_idx <= 1'b1;
            else begin
              tx_state <= S_IDLE;
              tx_ready <= 1'b1;
            end
          end else tx_cnt <= tx_cnt + CNT_W'(1);
        end
        default: tx_state <= S_IDLE;
      endcase
    end
  end

  // Synchroniser stage boundary: p0 metastable capture, p1 usable
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_p0 <= 1'b1;
      rx_sync_p1 <= 1'b1;
    end else begin
      rx_meta_p0 <= rx;
      rx_sync_p1 <= rx_meta_p0;
    end
  end

  assign rx_line    = lb_act ? tx_bit : rx_sync_p1;
  assign frame_done = (rx_state == S_STOP) && (rx_cnt == LAST_CNT);

  // RX: start needs a true high-to-low edge, so a held-low break re-arms only after the line rises
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_state      <= S_IDLE;
      rx_cnt        <= '0;
      rx_idx        <= '0;
      rx_prev       <= 1'b1;
      vld_p1        <= 1'b0;
      rx_valid      <= 1'b0;
      rx_data       <= '0;
      rx_parity_err <= 1'b0;
      rx_frame_err  <= 1'b0;
      rx_overrun    <= 1'b0;
    end else begin
      rx_prev <= rx_line;
      vld_p1  <= 1'b0;
      if (vld_p1) rx_valid <= 1'b1;
      else if (rx_valid && rx_ready && !frame_done) rx_valid <= 1'b0;
      case (rx_state)
        S_IDLE: begin
          if (rx_prev && !rx_line) begin
            rx_cnt   <= '0;
            rx_state <= S_START;
          end
        end
        S_START: begin
          if (rx_cnt == MID_CNT) begin
            rx_cnt   <= '0;
            rx_idx   <= '0;
            rx_state <= rx_line ? S_IDLE : S_DATA;
          end else rx_cnt <= rx_cnt + CNT_W'(1);
        end
        S_DATA: begin
          if (rx_cnt == LAST_CNT) begin
            rx_cnt   <= '0;
            rx_shift <= {rx_line, rx_shift[DATA_BITS-1:1]};
            rx_idx   <= rx_idx + BIT_W'(1);
            if (rx_idx == LAST_BIT) rx_state <= (PARITY_EN != 0) ? S_PARITY : S_STOP;
          end else rx_cnt <= rx_cnt + CNT_W'(1);
        end
        S_PARITY: begin
          if (rx_cnt == LAST_CNT) begin
            rx_cnt   <= '0;
            rx_par   <= rx_line;
            rx_state <= S_STOP;
          end else rx_cnt <= rx_cnt + CNT_W'(1);
        end
        S_STOP: begin
          if (rx_cnt == LAST_CNT) begin
            rx_cnt   <= '0;
            rx_state <= S_IDLE;
            if (rx_valid && !rx_ready) rx_overrun <= 1'b1;
            else begin
              rx_data       <= rx_shift;
              rx_parity_err <= (PARITY_EN != 0) && (parity_of(rx_shift) != rx_par);
              rx_frame_err  <= !rx_line;
              vld_p1        <= !rx_valid;
            end
          end else rx_cnt <= rx_cnt + CNT_W'(1);
        end
        default: rx_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_core.sv
// Directed bench for uart_core: one instance without parity, one with even parity.
module tb_uart_core;
  localparam int CPB = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [7:0] tx_data0, tx_data1, rx_data0, rx_data1;
  logic       tx_valid0, tx_valid1, tx_ready0, tx_ready1, tx0, tx1, rx0, rx1;
  logic       rx_valid0, rx_valid1, rx_ready0, rx_ready1;
  logic       rx_parity_err0, rx_parity_err1, rx_frame_err0, rx_frame_err1;
  logic       rx_overrun0, rx_overrun1, loopback0, loopback1;

  int total = 0;
  int bad = 0;

  uart_core #(.CLKS_PER_BIT(CPB)) u0 (
    .clk(clk), .rst(rst), .tx_data(tx_data0), .tx_valid(tx_valid0), .tx_ready(tx_ready0),
    .tx(tx0), .rx(rx0), .rx_data(rx_data0), .rx_valid(rx_valid0), .rx_ready(rx_ready0),
    .rx_parity_err(rx_parity_err0), .rx_frame_err(rx_frame_err0), .rx_overrun(rx_overrun0),
    .loopback(loopback0)
  );

  uart_core #(.CLKS_PER_BIT(CPB), .PARITY_EN(1), .PARITY_ODD(0)) u1 (
    .clk(clk), .rst(rst), .tx_data(tx_data1), .tx_valid(tx_valid1), .tx_ready(tx_ready1),
    .tx(tx1), .rx(rx1), .rx_data(rx_data1), .rx_valid(rx_valid1), .rx_ready(rx_ready1),
    .rx_parity_err(rx_parity_err1), .rx_frame_err(rx_frame_err1), .rx_overrun(rx_overrun1),
    .loopback(loopback1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit sel, input logic b);
    if (sel) rx1 = b;
    else rx0 = b;
  endtask

  // Serial frame on the rx pin: start, 8 data LSB first, optional parity, one stop.
  task automatic send_rx(input bit sel, input logic [7:0] d, input bit par_en,
                         input logic par, input logic stop);
    int n;
    logic b;
    n = par_en ? 11 : 10;
    for (int i = 0; i < n; i++) begin
      if (i == 0) b = 1'b0;
      else if (i <= 8) b = d[i-1];
      else if (par_en && i == 9) b = par;
      else b = stop;
      drive(sel, b);
      repeat (CPB) tick();
    end
    drive(sel, 1'b1);
  endtask

  task automatic wait_vld(input bit sel, input string tag);
    int n;
    n = 0;
    while (!(sel ? rx_valid1 : rx_valid0) && n < 20) begin
      tick();
      n++;
    end
    chk(tag, sel ? rx_valid1 : rx_valid0, 1);
  endtask

  initial begin
    logic [9:0] pat;
    logic [7:0] got_d [2];
    logic       got_pe [2];
    logic       got_fe [2];
    logic       acc;
    int         nv;
    bit         tx_hi;

    rst = 1'b1;
    tx_data0 = '0; tx_data1 = '0; tx_valid0 = 1'b0; tx_valid1 = 1'b0;
    rx0 = 1'b1; rx1 = 1'b1; rx_ready0 = 1'b0; rx_ready1 = 1'b0;
    loopback0 = 1'b0; loopback1 = 1'b0;
    repeat (3) tick();

    chk("rst_tx", tx0, 1);
    chk("rst_tx_ready", tx_ready0, 0);
    chk("rst_rx_valid", rx_valid0, 0);
    chk("rst_rx_data", rx_data0, 0);
    chk("rst_perr", rx_parity_err0, 0);
    chk("rst_ferr", rx_frame_err0, 0);
    chk("rst_ovr", rx_overrun0, 0);
    chk("rst_tx_u1", tx1, 1);
    chk("rst_tx_ready_u1", tx_ready1, 0);
    rst = 1'b0;
    tick();
    chk("post_rst_tx_ready", tx_ready0, 1);

    // 0xA5, no parity: start, 1,0,1,0,0,1,0,1, stop
    pat = 10'b11_0100_1010;
    tx_data0 = 8'hA5; tx_valid0 = 1'b1;
    tick();
    tx_valid0 = 1'b0;
    for (int i = 0; i < 40; i++) begin
      chk("a5_tx_bit", tx0, pat[i/4]);
      chk("a5_tx_ready_low", tx_ready0, 0);
      tick();
    end
    chk("a5_tx_ready_back", tx_ready0, 1);
    chk("a5_tx_idle", tx0, 1);

    // Loopback, 0xFF then 0x00 back to back
    rx_ready0 = 1'b1;
    loopback0 = 1'b1;
    tick(); tick();
    tx_data0 = 8'hFF; tx_valid0 = 1'b1;
    tick();
    tx_data0 = 8'h00;
    nv = 0; tx_hi = 1'b1;
    for (int i = 0; i < 110; i++) begin
      acc = tx_ready0 && tx_valid0;
      tick();
      if (acc) tx_valid0 = 1'b0;
      if (tx0 !== 1'b1) tx_hi = 1'b0;
      if (rx_valid0 === 1'b1) begin
        if (nv < 2) begin
          got_d[nv] = rx_data0; got_pe[nv] = rx_parity_err0; got_fe[nv] = rx_frame_err0;
        end
        nv++;
      end
    end
    chk("lb_count", nv, 2);
    chk("lb_word0", got_d[0], 8'hFF);
    chk("lb_word1", got_d[1], 8'h00);
    chk("lb_perr0", got_pe[0], 0);
    chk("lb_ferr0", got_fe[0], 0);
    chk("lb_perr1", got_pe[1], 0);
    chk("lb_ferr1", got_fe[1], 0);
    chk("lb_tx_pin_high", tx_hi, 1);
    tx_valid0 = 1'b0;
    loopback0 = 1'b0;
    rx_ready0 = 1'b0;
    tick(); tick();

    // One-cycle glitch must not start a frame
    rx0 = 1'b0;
    tick();
    rx0 = 1'b1;
    nv = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (rx_valid0 !== 1'b0) nv++;
    end
    chk("glitch_no_valid", nv, 0);

    // Overrun: two frames with rx_ready low
    send_rx(1'b0, 8'h3C, 1'b0, 1'b0, 1'b1);
    wait_vld(1'b0, "ovr_first_valid");
    chk("ovr_first_data", rx_data0, 8'h3C);
    chk("ovr_first_ferr", rx_frame_err0, 0);
    chk("ovr_not_yet", rx_overrun0, 0);
    send_rx(1'b0, 8'hC3, 1'b0, 1'b0, 1'b1);
    repeat (4) tick();
    chk("ovr_keep_data", rx_data0, 8'h3C);
    chk("ovr_keep_valid", rx_valid0, 1);
    chk("ovr_flag", rx_overrun0, 1);
    rx_ready0 = 1'b1;
    tick();
    rx_ready0 = 1'b0;
    chk("ovr_read_clears_valid", rx_valid0, 0);
    chk("ovr_sticky", rx_overrun0, 1);
    chk("ovr_data_after_read", rx_data0, 8'h3C);

    // Break: line held low yields exactly one word with frame error
    rx_ready0 = 1'b1;
    rx0 = 1'b0;
    nv = 0;
    for (int i = 0; i < 90; i++) begin
      tick();
      if (rx_valid0 === 1'b1) begin
        if (nv < 1) begin got_d[0] = rx_data0; got_fe[0] = rx_frame_err0; end
        nv++;
      end
    end
    rx0 = 1'b1;
    rx_ready0 = 1'b0;
    repeat (6) tick();
    chk("break_count", nv, 1);
    chk("break_data", got_d[0], 8'h00);
    chk("break_ferr", got_fe[0], 1);

    // Even parity: 0x03 with parity 1 is an error
    send_rx(1'b1, 8'h03, 1'b1, 1'b1, 1'b1);
    wait_vld(1'b1, "par_bad_valid");
    chk("par_bad_data", rx_data1, 8'h03);
    chk("par_bad_perr", rx_parity_err1, 1);
    chk("par_bad_ferr", rx_frame_err1, 0);
    rx_ready1 = 1'b1;
    tick();
    rx_ready1 = 1'b0;
    chk("par_bad_consumed", rx_valid1, 0);

    send_rx(1'b1, 8'h07, 1'b1, 1'b1, 1'b1);
    wait_vld(1'b1, "par_ok_valid");
    chk("par_ok_data", rx_data1, 8'h07);
    chk("par_ok_perr", rx_parity_err1, 0);

    // Frame completes on the same edge as the read: new word loads, no overrun
    send_rx(1'b1, 8'h81, 1'b1, 1'b0, 1'b0);
    rx_ready1 = 1'b1;
    tick();
    rx_ready1 = 1'b0;
    repeat (2) tick();
    chk("same_edge_valid", rx_valid1, 1);
    chk("same_edge_data", rx_data1, 8'h81);
    chk("same_edge_ferr", rx_frame_err1, 1);
    chk("same_edge_perr", rx_parity_err1, 0);
    chk("same_edge_no_ovr", rx_overrun1, 0);
    rx_ready1 = 1'b1;
    tick();
    rx_ready1 = 1'b0;
    chk("same_edge_consumed", rx_valid1, 0);

    // Reset during TX data bit 3 of 0xA5 (bit value 0)
    tx_data0 = 8'hA5; tx_valid0 = 1'b1;
    tick();
    tx_valid0 = 1'b0;
    repeat (17) tick();
    chk("mid_rst_tx_low", tx0, 0);
    rst = 1'b1;
    tick();
    chk("mid_rst_tx_high", tx0, 1);
    chk("mid_rst_tx_ready_low", tx_ready0, 0);
    chk("mid_rst_ovr_clear", rx_overrun0, 0);
    chk("mid_rst_rx_data", rx_data0, 0);
    chk("mid_rst_rx_valid", rx_valid0, 0);
    rst = 1'b0;
    tick();
    chk("mid_rst_tx_ready_back", tx_ready0, 1);
    chk("mid_rst_tx_idle", tx0, 1);

    // Reset mid-frame in loopback: no partial word
    loopback0 = 1'b1;
    rx_ready0 = 1'b1;
    tick(); tick();
    tx_data0 = 8'h5A; tx_valid0 = 1'b1;
    tick();
    tx_valid0 = 1'b0;
    repeat (17) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    nv = 0;
    for (int i = 0; i < 80; i++) begin
      tick();
      if (rx_valid0 !== 1'b0) nv++;
    end
    chk("lb_rst_no_valid", nv, 0);
    chk("lb_rst_tx_ready", tx_ready0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
